prince_linear_layer: RTL and testbench
======================================

Name: prince_linear_layer

Overview:
- Registered PRINCE linear-layer datapath with key and round-constant addition.
- Forward mode implements one forward round's back half, M then add key xor rc; the S-box is applied upstream.
- Inverse mode implements one inverse round's front half, add key xor rc then M^-1; the inverse S-box is applied downstream.
- Sits between the S-box stages of a round-based PRINCE core and replaces the separate add-key, M and M^-1 blocks.

Parameters:
- none

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  qualifies data_in/key/rc/mode this cycle
- mode  input  1  0 = forward (M then xor), 1 = inverse (xor then M^-1)
- data_in  input  64  state word; nibble n0 = bits 63:60 … n15 = bits 3:0
- key  input  64  round key (k1)
- rc  input  64  round constant
- out_valid  output  1  data_out holds a new result
- data_out  output  64  registered result

Behaviour:
- Clocking: one clock (clk). Reset is synchronous and active-high (rst). On rst at a rising edge, data_out <= 0 and out_valid <= 0; rst has priority over in_valid.
- Latency: exactly 1 cycle.
  - in_valid=1 at edge t → data_out = f(inputs sampled at t) and out_valid=1 after edge t.
  - in_valid=0 → out_valid <= 0 and data_out holds its previous value.
  - Full throughput: a new operation may start every cycle. No backpressure.
- Definitions:
  - Nibble bit position b=0 is the nibble MSB, b=3 the LSB.
  - Mk (k=0..3) is a 4-bit mask that zeroes bit position k and passes the other three bits.
- M̂0 on a 16-bit chunk with nibbles a0..a3 (a0 = chunk MSBs): out nibble i = XOR over j=0..3 of M_{(i+j) mod 4}(a_j).
- M̂1: same as M̂0 but using M_{(i+j+1) mod 4}.
- M' (involution):
  - chunk bits 63:48 → M̂0
  - chunk bits 47:32 → M̂1
  - chunk bits 31:16 → M̂1
  - chunk bits 15:0 → M̂0
- SR: out nibble i = in nibble P[i], with P = 0,5,10,15,4,9,14,3,8,13,2,7,12,1,6,11.
- SR^-1 uses P^-1 = 0,13,10,7,4,1,14,11,8,5,2,15,12,9,6,3.
- Forward: result = SR(M'(data_in)) ^ key ^ rc.
- Inverse: result = M'(SR^-1(data_in ^ key ^ rc)).
- Whole datapath is combinational XOR/wiring in front of the output register. No arithmetic carries, no internal state other than data_out and out_valid.
- mode is sampled with data; switching mode between consecutive cycles is legal and takes effect per operation.
- Reset asserted mid-stream discards the result being captured that cycle. The first valid input after rst deasserts is processed normally.

Test Plan:
- Reset: assert rst with in_valid=1 and nonzero data → next cycle data_out=0, out_valid=0. Deassert, in_valid=0 → out_valid stays 0.
- Forward single bit: mode=0, data_in=0x8000000000000000, key=rc=0.
  - Expected M' = 0x0888000000000000.
  - Expected data_out = 0x0000000800800800 one cycle later, out_valid=1.
- Inverse round-trip: mode=1, data_in=0x0000000800800800, key=rc=0 → data_out = 0x8000000000000000.
- Key/constant addition:
  - mode=0, data_in=0, key=0, rc=0x13198A2E03707344 → data_out = 0x13198A2E03707344.
  - mode=1, data_in=0x13198A2E03707344, same key/rc → data_out = 0.
- Cancellation: key=rc=0x0123456789ABCDEF, random data_in, both modes → data_out equals pure M (forward) or M^-1 (inverse) of data_in.
- Back-to-back plus mode toggle: 100 random vectors with in_valid held high and mode alternating; model check per cycle. Also check inverse(forward(x, k, rc), k, rc) = x.

Source files
------------

// File: rtl/prince_linear_layer.sv
// prince_linear_layer: PRINCE linear layer fused with round-key/round-constant addition.
// Latency: 1 cycle (in_valid at edge t -> out_valid/data_out after edge t), full throughput.
// Backpressure: none; a new operation is accepted every cycle in_valid is high.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset (clears out_valid and data_out)
//   in_valid  qualifies data_in/key/rc/mode this cycle
//   mode      0 = forward: SR(M'(data_in)) ^ key ^ rc
//             1 = inverse: M'(SR^-1(data_in ^ key ^ rc))
//   data_in   64-bit state, nibble n0 = bits 63:60 ... n15 = bits 3:0
//   key, rc   round key and round constant
//   out_valid data_out holds a new result
//   data_out  registered result; held while in_valid is low
module prince_linear_layer (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        mode,
    input  logic [63:0] data_in,
    input  logic [63:0] key,
    input  logic [63:0] rc,
    output logic        out_valid,
    output logic [63:0] data_out
);

    // ShiftRows nibble permutation and its inverse: out nibble i = in nibble P[i].
    localparam int SR_FWD [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};
    localparam int SR_INV [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};

    // M_k clears nibble bit position k, where position 0 is the nibble MSB.
    function automatic logic [3:0] m_mask(input logic [1:0] k);
        return ~(4'b1000 >> k);
    endfunction

    // M-hat on one 16-bit chunk; rot=1 selects M-hat1 (mask index offset by one).
    function automatic logic [15:0] m_hat(input logic [15:0] c, input logic [1:0] rot);
        logic [15:0] r;
        logic [3:0]  acc;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            acc = '0;
            for (int j = 0; j < 4; j++) begin
                acc = acc ^ (c[15-4*j -: 4] & m_mask(2'(i + j) + rot));
            end
            r[15-4*i -: 4] = acc;
        end
        return r;
    endfunction

    // M' is an involution, so the same block serves both directions.
    function automatic logic [63:0] m_prime(input logic [63:0] x);
        return {m_hat(x[63:48], 2'd0), m_hat(x[47:32], 2'd1),
                m_hat(x[31:16], 2'd1), m_hat(x[15:0],  2'd0)};
    endfunction

    function automatic logic [63:0] shift_rows(input logic [63:0] x, input logic inv);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (inv) r[63-4*i -: 4] = x[63-4*SR_INV[i] -: 4];
            else     r[63-4*i -: 4] = x[63-4*SR_FWD[i] -: 4];
        end
        return r;
    endfunction

    logic [63:0] tweak;
    logic [63:0] result;

    assign tweak = key ^ rc;

    always_comb begin
        result = '0;
        if (mode) result = m_prime(shift_rows(data_in ^ tweak, 1'b1));
        else      result = shift_rows(m_prime(data_in), 1'b0) ^ tweak;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            data_out  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) data_out <= result;
        end
    end

endmodule

// File: tb/tb_prince_linear_layer.sv
// tb_prince_linear_layer: randomized self-checking bench for prince_linear_layer.
// Latency: expects results one cycle after in_valid; compares every cycle on negedge.
// Backpressure: none exercised (design has none).
module tb_prince_linear_layer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        mode;
    logic [63:0] data_in;
    logic [63:0] key;
    logic [63:0] rc;
    logic        out_valid;
    logic [63:0] data_out;

    int checks   = 0;
    int failures = 0;

    prince_linear_layer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .mode      (mode),
        .data_in   (data_in),
        .key       (key),
        .rc        (rc),
        .out_valid (out_valid),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (nibble arrays, table lookups) ----------------
    typedef logic [3:0] nib_t;
    typedef nib_t nibs_t [16];

    int   perm_fwd [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};
    int   perm_inv [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};
    nib_t mask_tab [4]  = '{4'h7, 4'hB, 4'hD, 4'hE};

    function automatic nibs_t split(input logic [63:0] x);
        nibs_t n;
        for (int i = 0; i < 16; i++) n[i] = nib_t'(x >> (60 - 4*i));
        return n;
    endfunction

    function automatic logic [63:0] join_nibs(input nibs_t n);
        logic [63:0] x = '0;
        for (int i = 0; i < 16; i++) x = (x << 4) | 64'(n[i]);
        return x;
    endfunction

    function automatic logic [63:0] ref_m(input logic [63:0] x);
        nibs_t a = split(x);
        nibs_t o;
        int    off;
        for (int c = 0; c < 4; c++) begin
            off = (c == 1 || c == 2) ? 1 : 0;
            for (int i = 0; i < 4; i++) begin
                o[4*c+i] = 4'h0;
                for (int j = 0; j < 4; j++)
                    o[4*c+i] = o[4*c+i] ^ (a[4*c+j] & mask_tab[(i + j + off) % 4]);
            end
        end
        return join_nibs(o);
    endfunction

    function automatic logic [63:0] ref_sr(input logic [63:0] x, input bit inv);
        nibs_t a = split(x);
        nibs_t o;
        for (int i = 0; i < 16; i++) o[i] = inv ? a[perm_inv[i]] : a[perm_fwd[i]];
        return join_nibs(o);
    endfunction

    function automatic logic [63:0] ref_op(input bit md, input logic [63:0] d,
                                           input logic [63:0] k, input logic [63:0] r);
        if (md) return ref_m(ref_sr(d ^ k ^ r, 1'b1));
        return ref_sr(ref_m(d), 1'b0) ^ k ^ r;
    endfunction

    // ---------------- cycle model + per-cycle compare ----------------
    logic        exp_valid;
    logic [63:0] exp_data;
    bit          model_live = 0;

    always @(posedge clk) begin
        if (rst) begin
            exp_valid  = 1'b0;
            exp_data   = '0;
            model_live = 1;
        end else if (in_valid) begin
            exp_valid = 1'b1;
            exp_data  = ref_op(mode, data_in, key, rc);
        end else begin
            exp_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            checks++;
            if (out_valid !== exp_valid) begin
                failures++;
                $display("FAIL cyc_valid t=%0t got=%b exp=%b", $time, out_valid, exp_valid);
            end
            checks++;
            if (data_out !== exp_data) begin
                failures++;
                $display("FAIL cyc_data t=%0t got=%h exp=%h", $time, data_out, exp_data);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs (at negedge), then sample just after the next posedge.
    task automatic step(input bit v, input bit md, input logic [63:0] d,
                        input logic [63:0] k, input logic [63:0] r);
        @(negedge clk);
        in_valid = v; mode = md; data_in = d; key = k; rc = r;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    localparam logic [63:0] RC1 = 64'h13198A2E03707344;
    localparam logic [63:0] CK  = 64'h0123456789ABCDEF;

    logic [63:0] x, k, r, y;

    initial begin
        rst = 1'b1; in_valid = 1'b0; mode = 1'b0;
        data_in = '0; key = '0; rc = '0;

        // Model pins against hand-computed values.
        check64("model_mprime", ref_m(64'h8000000000000000), 64'h0888000000000000);
        check64("model_fwd",    ref_op(1'b0, 64'h8000000000000000, 0, 0), 64'h0000000800800800);
        check64("model_inv",    ref_op(1'b1, 64'h0000000800800800, 0, 0), 64'h8000000000000000);

        // Reset wins over in_valid with nonzero data.
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; data_in = 64'hFFFF_0000_1234_5678; key = CK;
        @(posedge clk); #1;
        check1("rst_valid", out_valid, 1'b0);
        check64("rst_data", data_out, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b0, 64'hDEAD_BEEF_0000_0001, 0, 0);
        check1("idle_after_rst", out_valid, 1'b0);

        // Directed vectors.
        step(1'b1, 1'b0, 64'h8000000000000000, 0, 0);
        check1("fwd_bit_valid", out_valid, 1'b1);
        check64("fwd_bit", data_out, 64'h0000000800800800);
        step(1'b1, 1'b1, 64'h0000000800800800, 0, 0);
        check64("inv_bit", data_out, 64'h8000000000000000);
        step(1'b1, 1'b0, 64'h0, 0, RC1);
        check64("fwd_rc", data_out, RC1);
        step(1'b1, 1'b1, RC1, 0, RC1);
        check64("inv_rc", data_out, 64'h0);

        // Hold: in_valid low keeps data_out.
        step(1'b0, 1'b1, rnd64(), rnd64(), rnd64());
        check1("hold_valid", out_valid, 1'b0);
        check64("hold_data", data_out, 64'h0);

        // Cancellation: key == rc leaves the pure linear layer.
        for (int i = 0; i < 8; i++) begin
            x = rnd64();
            step(1'b1, i[0], x, CK, CK);
            check64("cancel", data_out, ref_op(i[0], x, 64'h0, 64'h0));
        end

        // Round trip inverse(forward(x)) == x.
        for (int i = 0; i < 8; i++) begin
            x = rnd64(); k = rnd64(); r = rnd64();
            step(1'b1, 1'b0, x, k, r);
            y = data_out;
            step(1'b1, 1'b1, y, k, r);
            check64("roundtrip", data_out, x);
        end

        // Back-to-back, alternating mode, 100 vectors.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            in_valid = 1'b1; mode = i[0];
            data_in = rnd64(); key = rnd64(); rc = rnd64();
        end

        // Random gaps.
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) != 0);
            mode = 1'($urandom);
            data_in = rnd64(); key = rnd64(); rc = rnd64();
        end

        // Mid-stream reset discards the result, next valid is processed.
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; data_in = rnd64();
        @(posedge clk); #1;
        check1("mid_rst_valid", out_valid, 1'b0);
        check64("mid_rst_data", data_out, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 64'h8000000000000000, 0, 0);
        check64("after_rst", data_out, 64'h0000000800800800);

        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
